aw_video_page_engine: RTL and testbench
=======================================

Name: aw_video_page_engine

Overview:
- Executes the VM's video-page commands: select work page, fill page, copy page, blit (present) frame buffer.
- Receives them from the bytecode CPU over a valid/ready command channel and performs the pixel writes into the external 4-page, 4-bit-per-pixel VRAM.
- Exports the front-page index to the scanout path.
- Owns the front/back/work page pointers exactly as the original VM defines them.

Parameters:
- PAGE_PIXELS, 64000, pixels per page (320x200).
- ADDR_W, 18, VRAM address width; must hold 4*PAGE_PIXELS-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  command code: 0=select, 1=fill, 2=copy, 3=blit
- cmd_arg_a  in  8  page id (select/fill/blit), source page id (copy)
- cmd_arg_b  in  8  fill colour in bits [3:0] (fill); destination page id (copy)
- vram_re  out  1  read strobe
- vram_raddr  out  ADDR_W  read address
- vram_rdata  in  4  read data, valid exactly 1 cycle after vram_re
- vram_we  out  1  write strobe
- vram_waddr  out  ADDR_W  write address
- vram_wdata  out  4  write data
- front_page  out  2  page shown by scanout
- busy  out  1  fill or copy in progress
- cmd_done  out  1  1-cycle pulse when any command completes

Behaviour:
- Reset is checked every cycle and overrides everything. Reset values:
  - front=2, back=1, work=1
  - cmd_ready=1, busy=0
  - vram_we=0, vram_re=0, cmd_done=0
  - all addresses and data 0
  - state IDLE
- Page-id resolution, res(x):
  - x<=3 -> x
  - 0xFF -> back
  - 0xFE -> front
  - any other value -> 0
- Copy source only: if arg_a[7]=1 and arg_a<0xFE, source = arg_a[1:0]. There is no vertical scroll.
- Pixel address = page*PAGE_PIXELS + offset. Compute with the multiplier-free form (page<<16) - (page<<10) - (page<<9) + offset, which equals page*64000 + offset; result is ADDR_W bits.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - cmd_ready = (state==IDLE) & reset.
- Single-cycle commands, applied in the accept cycle (visible the next cycle); cmd_done pulses the next cycle and the engine stays in IDLE:
  - select: work <= res(arg_a).
  - blit, arg_a==0xFE: no change.
  - blit, arg_a==0xFF: front<->back swap, applied atomically.
  - blit, other arg_a: front <= res(arg_a).
  - Work page is never changed by blit.
- fill, IDLE->FILL:
  - Latch the destination page and colour at accept.
  - Offsets 0..PAGE_PIXELS-1, one write per cycle, starting the cycle after accept.
  - After the last write, return to IDLE with cmd_done pulsed one cycle later.
  - Total: PAGE_PIXELS write cycles.
- copy, IDLE->COPY:
  - If res(src)==res(dst): no memory traffic, behaves as a single-cycle command.
  - Otherwise pipelined: cycle k issues a read at offset k; cycle k+1 writes vram_rdata to the destination at offset k.
  - PAGE_PIXELS reads, then one drain cycle for the last write; cmd_done is pulsed after the final write.
  - Reads and writes overlap in the same cycle.
- busy = state in {FILL, COPY}. cmd_ready=0 while busy; cmd_valid is ignored while busy.
- Operands are latched at accept; changes on cmd_arg_* during an operation have no effect.
- Pointers used by a fill/copy are resolved at accept. front_page changes only via blit.
- Reset mid-operation:
  - Abort on the reset cycle; no further vram_we or vram_re.
  - All pointers return to their reset values; cmd_done is not pulsed.
- The offset counter is 16-bit and never wraps past PAGE_PIXELS-1. The terminal compare is on PAGE_PIXELS-1.
- vram_we and vram_re are never asserted in IDLE.

Test Plan:
- After reset: front_page=2, cmd_ready=1, busy=0, no strobes. Then select 0xFF followed by fill 0xFE colour 7 -> writes hit addresses 128000..191999, all with data 7.
- fill arg_a=0 colour 5 -> exactly 64000 vram_we cycles, addresses 0..63999, wdata=5, cmd_ready=0 throughout, then one cmd_done.
- copy src=1, dst=3, memory model returning rdata=addr[3:0] -> write address 192000+k carries (64000+k)&0xF. Exactly 64000 writes, first write 1 cycle after first read.
- blit 0xFF -> front=1 (back becomes 2); blit 0xFF again -> front=2. blit 0xFE -> no change. blit 3 -> front=3. cmd_done pulses once per blit.
- copy 0xFF->1 with back=1 -> cmd_done next cycle, no reads or writes. copy 0x82->0 -> source page 2.
- Assert reset at pixel 1000 of a fill -> vram_we=0 from the reset cycle on, no cmd_done, pointers restored to 2/1/1, next command accepted immediately.

Source files
------------

// File: rtl/aw_video_page_engine.sv
// Video-page command engine: owns the front/back/work page pointers and
// streams fill/copy pixel traffic into the 4-page, 4-bit-per-pixel VRAM.
module aw_video_page_engine #(
    parameter int PAGE_PIXELS = 64000,
    parameter int ADDR_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [7:0]        cmd_arg_a,
    input  logic [7:0]        cmd_arg_b,
    output logic              vram_re,
    output logic [ADDR_W-1:0] vram_raddr,
    input  logic [3:0]        vram_rdata,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_waddr,
    output logic [3:0]        vram_wdata,
    output logic [1:0]        front_page,
    output logic              busy,
    output logic              cmd_done
);
    localparam logic [1:0]  OP_SEL  = 2'd0;
    localparam logic [1:0]  OP_FILL = 2'd1;
    localparam logic [1:0]  OP_COPY = 2'd2;
    localparam logic [15:0] LAST    = 16'(PAGE_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, FILL, COPY} state_t;

    state_t      state, state_nxt;
    logic [1:0]  front, back, work;
    logic [1:0]  src, dst;
    logic [3:0]  colour;
    logic [15:0] rd_off, wr_off;
    logic        wr_pend, draining, done_q;
    logic        accept;
    logic [1:0]  res_a, res_b, src_res;

    // The work page is tracked for the VM but no datapath here consumes it.
    logic unused_work;
    assign unused_work = ^work;

    function automatic logic [1:0] resolve(input logic [7:0] x, input logic [1:0] f,
                                           input logic [1:0] b);
        if (x <= 8'd3)       return x[1:0];
        else if (x == 8'hFF) return b;
        else if (x == 8'hFE) return f;
        else                 return 2'd0;
    endfunction

    // page*64000 without a multiplier; other page sizes fall back to a constant product
    function automatic logic [ADDR_W-1:0] page_base(input logic [1:0] p);
        logic [ADDR_W-1:0] pw;
        pw = ADDR_W'(p);
        if (PAGE_PIXELS == 64000) return (pw << 16) - (pw << 10) - (pw << 9);
        else                      return ADDR_W'(p * PAGE_PIXELS);
    endfunction

    assign res_a   = resolve(cmd_arg_a, front, back);
    assign res_b   = resolve(cmd_arg_b, front, back);
    assign src_res = (cmd_arg_a[7] && cmd_arg_a < 8'hFE) ? cmd_arg_a[1:0] : res_a;
    assign accept  = cmd_valid & cmd_ready;

    assign front_page = front;
    assign cmd_done   = done_q;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cmd_ready  = (state == IDLE) && reset;
        busy       = (state != IDLE) && reset;
        vram_re    = 1'b0;
        vram_raddr = '0;
        vram_we    = 1'b0;
        vram_waddr = '0;
        vram_wdata = '0;
        unique case (state)
            IDLE: if (accept) begin
                if (cmd_op == OP_FILL)                           state_nxt = FILL;
                else if (cmd_op == OP_COPY && src_res != res_b)  state_nxt = COPY;
            end
            FILL: begin
                vram_we    = 1'b1;
                vram_waddr = page_base(dst) + ADDR_W'(wr_off);
                vram_wdata = colour;
                if (wr_off == LAST) state_nxt = IDLE;
            end
            COPY: begin
                vram_re    = !draining;
                vram_raddr = page_base(src) + ADDR_W'(rd_off);
                vram_we    = wr_pend;
                vram_waddr = page_base(dst) + ADDR_W'(wr_off);
                vram_wdata = vram_rdata;
                if (draining) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset kills strobes in the same cycle it is asserted.
        if (!reset) begin
            state_nxt  = IDLE;
            vram_re    = 1'b0;
            vram_raddr = '0;
            vram_we    = 1'b0;
            vram_waddr = '0;
            vram_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            front    <= 2'd2;
            back     <= 2'd1;
            work     <= 2'd1;
            src      <= '0;
            dst      <= '0;
            colour   <= '0;
            rd_off   <= '0;
            wr_off   <= '0;
            wr_pend  <= 1'b0;
            draining <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    rd_off   <= '0;
                    wr_off   <= '0;
                    wr_pend  <= 1'b0;
                    draining <= 1'b0;
                    case (cmd_op)
                        OP_SEL: begin
                            work   <= res_a;
                            done_q <= 1'b1;
                        end
                        OP_FILL: begin
                            dst    <= res_a;
                            colour <= cmd_arg_b[3:0];
                        end
                        OP_COPY: begin
                            src    <= src_res;
                            dst    <= res_b;
                            done_q <= (src_res == res_b);
                        end
                        default: begin
                            if (cmd_arg_a == 8'hFF) begin
                                front <= back;
                                back  <= front;
                            end else if (cmd_arg_a != 8'hFE) begin
                                front <= res_a;
                            end
                            done_q <= 1'b1;
                        end
                    endcase
                end
                FILL: begin
                    if (wr_off == LAST) done_q <= 1'b1;
                    else                wr_off <= wr_off + 16'd1;
                end
                COPY: begin
                    // Write side trails the read side by one cycle (VRAM read latency).
                    wr_pend <= !draining;
                    wr_off  <= rd_off;
                    if (draining)             done_q   <= 1'b1;
                    else if (rd_off == LAST)  draining <= 1'b1;
                    else                      rd_off   <= rd_off + 16'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aw_video_page_engine.sv
// Randomized bench for aw_video_page_engine against a pointer/page arithmetic model.
module tb_aw_video_page_engine;
    localparam int P  = 400;
    localparam int AW = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cmd_valid, cmd_ready, vram_re, vram_we, busy, cmd_done;
    logic [1:0]    cmd_op, front_page;
    logic [7:0]    cmd_arg_a, cmd_arg_b;
    logic [AW-1:0] vram_raddr, vram_waddr;
    logic [3:0]    vram_rdata, vram_wdata;

    logic          f_reset, f_valid, f_ready, f_re, f_we, f_busy, f_done;
    logic [1:0]    f_op, f_front;
    logic [7:0]    f_a, f_b;
    logic [AW-1:0] f_raddr, f_waddr;
    logic [3:0]    f_rdata, f_wdata;

    aw_video_page_engine #(.PAGE_PIXELS(P), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg_a(cmd_arg_a), .cmd_arg_b(cmd_arg_b),
        .vram_re(vram_re), .vram_raddr(vram_raddr), .vram_rdata(vram_rdata),
        .vram_we(vram_we), .vram_waddr(vram_waddr), .vram_wdata(vram_wdata),
        .front_page(front_page), .busy(busy), .cmd_done(cmd_done)
    );

    aw_video_page_engine dut_full (
        .clk(clk), .reset(f_reset), .cmd_valid(f_valid), .cmd_ready(f_ready),
        .cmd_op(f_op), .cmd_arg_a(f_a), .cmd_arg_b(f_b),
        .vram_re(f_re), .vram_raddr(f_raddr), .vram_rdata(f_rdata),
        .vram_we(f_we), .vram_waddr(f_waddr), .vram_wdata(f_wdata),
        .front_page(f_front), .busy(f_busy), .cmd_done(f_done)
    );

    int vectors = 0;
    int miscompares = 0;
    int m_front, m_back, m_work;
    logic [3:0] key = 4'd0;

    // VRAM read models: data returned one cycle after the read strobe.
    always @(posedge clk) vram_rdata <= vram_re ? (vram_raddr[3:0] ^ key) : 4'($urandom);
    always @(posedge clk) f_rdata <= f_raddr[3:0];

    int wa[$], wd[$], wcyc[$], ra[$], rcyc[$];
    int done_n, done_cyc, ready_bad, idle_strobe, busy_n, tmo;

    function automatic int res(int x);
        if (x <= 3)   return x;
        if (x == 255) return m_back;
        if (x == 254) return m_front;
        return 0;
    endfunction

    function automatic int src_of(int x);
        if (x >= 128 && x < 254) return x % 4;
        return res(x);
    endfunction

    function automatic logic [7:0] pick_id();
        int r;
        r = $urandom_range(0, 7);
        if (r <= 3) return 8'(r);
        if (r == 4) return 8'hFF;
        if (r == 5) return 8'hFE;
        if (r == 6) return 8'(8'h80 + $urandom_range(0, 8'h7D));
        return 8'($urandom_range(4, 8'h7F));
    endfunction

    // Issue one command and record all VRAM traffic until a few cycles past cmd_done.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int cyc, after, n;
        wa.delete(); wd.delete(); wcyc.delete(); ra.delete(); rcyc.delete();
        done_n = 0; done_cyc = -1; ready_bad = 0; idle_strobe = 0; busy_n = 0; tmo = 0;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n == 50) tmo = 1;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg_a = a; cmd_arg_b = b;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_arg_a = 8'($urandom); cmd_arg_b = 8'($urandom);
        cyc = 0; after = -1;
        while (after != 0 && cyc < 2 * P + 50) begin
            @(negedge clk); cyc++;
            if (vram_we) begin wa.push_back(int'(vram_waddr)); wd.push_back(int'(vram_wdata)); wcyc.push_back(cyc); end
            if (vram_re) begin ra.push_back(int'(vram_raddr)); rcyc.push_back(cyc); end
            if (busy) busy_n++;
            if (busy && cmd_ready) ready_bad++;
            if (!busy && (vram_we || vram_re)) idle_strobe++;
            if (cmd_done) begin done_n++; if (done_cyc < 0) done_cyc = cyc; end
            if (done_n > 0 && after < 0) after = 3;
            else if (after > 0) after--;
        end
        if (after != 0) tmo = 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_low: got %b want 0", cmd_ready); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (front_page !== 2'd2) begin miscompares++; $display("FAIL reset_front: got %0d want 2", front_page); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if ({vram_we, vram_re, cmd_done} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b want 000", {vram_we, vram_re, cmd_done}); end
        m_front = 2; m_back = 1; m_work = 1;
    endtask

    task automatic test_fill();
        logic [7:0] a;
        logic [3:0] c;
        int pg, bad;
        for (int it = 0; it < 4; it++) begin
            a = (it == 0) ? 8'd0 : pick_id();
            c = (it == 0) ? 4'd5 : 4'($urandom);
            pg = res(int'(a));
            run_cmd(2'd1, a, {4'($urandom), c});
            bad = 0;
            for (int k = 0; k < wa.size(); k++)
                if (wa[k] != pg * P + k || wd[k] != int'(c) || wcyc[k] != k + 1) bad++;
            vectors++; if (wa.size() != P) begin miscompares++; $display("FAIL fill_count a=%0h: got %0d want %0d", a, wa.size(), P); end
            vectors++; if (bad != 0) begin miscompares++; $display("FAIL fill_data a=%0h page=%0d: got %0d bad writes want 0", a, pg, bad); end
            vectors++; if (done_n != 1 || done_cyc != P + 1) begin miscompares++; $display("FAIL fill_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_n, done_cyc, P + 1); end
            vectors++; if (busy_n != P || ready_bad != 0) begin miscompares++; $display("FAIL fill_busy: got busy=%0d ready_bad=%0d want %0d/0", busy_n, ready_bad, P); end
            vectors++; if (ra.size() != 0 || idle_strobe != 0 || tmo != 0) begin miscompares++; $display("FAIL fill_misc: got reads=%0d idle=%0d tmo=%0d want 0", ra.size(), idle_strobe, tmo); end
            vectors++; if (int'(front_page) != m_front) begin miscompares++; $display("FAIL fill_front: got %0d want %0d", front_page, m_front); end
        end
    endtask

    task automatic test_copy();
        logic [7:0] a, b;
        int s, d, badr, badw;
        for (int it = 0; it < 6; it++) begin
            case (it)
                0: begin a = 8'd1;  b = 8'd3; end
                1: begin a = 8'hFF; b = 8'd1; end
                2: begin a = 8'h82; b = 8'd0; end
                default: begin a = pick_id(); b = pick_id(); end
            endcase
            key = 4'($urandom);
            s = src_of(int'(a)); d = res(int'(b));
            run_cmd(2'd2, a, b);
            if (s == d) begin
                vectors++; if (wa.size() != 0 || ra.size() != 0) begin miscompares++; $display("FAIL copy_same_traffic a=%0h b=%0h: got w=%0d r=%0d want 0", a, b, wa.size(), ra.size()); end
                vectors++; if (done_n != 1 || done_cyc != 1) begin miscompares++; $display("FAIL copy_same_done: got n=%0d cyc=%0d want 1/1", done_n, done_cyc); end
            end else begin
                badr = 0; badw = 0;
                for (int k = 0; k < ra.size(); k++)
                    if (ra[k] != s * P + k || rcyc[k] != k + 1) badr++;
                for (int k = 0; k < wa.size(); k++)
                    if (wa[k] != d * P + k || wd[k] != (((s * P + k) & 15) ^ int'(key)) || wcyc[k] != k + 2) badw++;
                vectors++; if (ra.size() != P || wa.size() != P) begin miscompares++; $display("FAIL copy_count a=%0h b=%0h: got r=%0d w=%0d want %0d", a, b, ra.size(), wa.size(), P); end
                vectors++; if (badr != 0) begin miscompares++; $display("FAIL copy_reads src=%0d: got %0d bad want 0", s, badr); end
                vectors++; if (badw != 0) begin miscompares++; $display("FAIL copy_writes dst=%0d: got %0d bad want 0", d, badw); end
                vectors++; if (done_n != 1 || done_cyc != P + 2) begin miscompares++; $display("FAIL copy_done: got n=%0d cyc=%0d want 1/%0d", done_n, done_cyc, P + 2); end
                vectors++; if (busy_n != P + 1 || ready_bad != 0) begin miscompares++; $display("FAIL copy_busy: got busy=%0d ready_bad=%0d want %0d/0", busy_n, ready_bad, P + 1); end
            end
            vectors++; if (idle_strobe != 0 || tmo != 0) begin miscompares++; $display("FAIL copy_misc: got idle=%0d tmo=%0d want 0", idle_strobe, tmo); end
        end
    endtask

    task automatic test_blit();
        logic [7:0] a;
        logic [3:0] c;
        int t;
        for (int it = 0; it < 14; it++) begin
            case (it)
                0, 1: a = 8'hFF;
                2:    a = 8'hFE;
                3:    a = 8'd3;
                default: a = pick_id();
            endcase
            if (it % 5 == 4) begin
                run_cmd(2'd0, a, 8'($urandom));
                m_work = res(int'(a));
            end else begin
                run_cmd(2'd3, a, 8'($urandom));
                if (a == 8'hFF) begin t = m_front; m_front = m_back; m_back = t; end
                else if (a != 8'hFE) m_front = res(int'(a));
            end
            vectors++; if (int'(front_page) != m_front) begin miscompares++; $display("FAIL blit_front it=%0d a=%0h: got %0d want %0d", it, a, front_page, m_front); end
            vectors++; if (done_n != 1 || done_cyc != 1 || wa.size() != 0 || ra.size() != 0) begin miscompares++; $display("FAIL blit_done it=%0d: got n=%0d cyc=%0d w=%0d r=%0d want 1/1/0/0", it, done_n, done_cyc, wa.size(), ra.size()); end
        end
        // Back pointer is only visible through page-id 0xFF.
        c = 4'($urandom);
        run_cmd(2'd1, 8'hFF, {4'd0, c});
        vectors++; if (wa.size() != P || wa[0] != m_back * P || wa[P - 1] != m_back * P + P - 1) begin miscompares++; $display("FAIL back_fill: got n=%0d first=%0d want n=%0d first=%0d", wa.size(), wa.size() > 0 ? wa[0] : -1, P, m_back * P); end
    endtask

    task automatic test_reset_abort();
        int strobe, dn, rdy_bad;
        run_cmd(2'd3, 8'd0, 8'd0);
        m_front = 0;
        for (int op = 1; op <= 2; op++) begin
            cmd_valid = 1'b1; cmd_op = 2'(op); cmd_arg_a = 8'd3; cmd_arg_b = 8'd1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            repeat (100) @(negedge clk);
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy op=%0d: got %b want 1", op, busy); end
            reset = 1'b0; #1;
            vectors++; if ({vram_we, vram_re, cmd_ready} !== 3'b000) begin miscompares++; $display("FAIL abort_same_cycle op=%0d: got we/re/rdy=%b want 000", op, {vram_we, vram_re, cmd_ready}); end
            @(posedge clk); #1;
            vectors++; if (front_page !== 2'd2 || busy !== 1'b0 || cmd_done !== 1'b0) begin miscompares++; $display("FAIL abort_state op=%0d: got front=%0d busy=%b done=%b want 2/0/0", op, front_page, busy, cmd_done); end
            @(negedge clk); reset = 1'b1;
            strobe = 0; dn = 0; rdy_bad = 0;
            repeat (4) begin
                @(negedge clk);
                if (vram_we || vram_re) strobe++;
                if (cmd_done) dn++;
                if (!cmd_ready) rdy_bad++;
            end
            vectors++; if (strobe != 0 || dn != 0 || rdy_bad != 0) begin miscompares++; $display("FAIL abort_after op=%0d: got strobes=%0d done=%0d notready=%0d want 0", op, strobe, dn, rdy_bad); end
            m_front = 2; m_back = 1; m_work = 1;
        end
        run_cmd(2'd3, 8'hFF, 8'd0);
        m_front = 1; m_back = 2;
        vectors++; if (front_page !== 2'd1 || done_cyc != 1) begin miscompares++; $display("FAIL abort_restore: got front=%0d done_cyc=%0d want 1/1", front_page, done_cyc); end
    endtask

    // Full 64000-pixel pages: check the page base arithmetic on a prefix of each stream.
    task automatic test_full_size();
        int bad, dn;
        f_reset = 1'b0; f_valid = 1'b0;
        repeat (2) @(negedge clk);
        f_reset = 1'b1; @(negedge clk);
        f_valid = 1'b1; f_op = 2'd0; f_a = 8'hFF; f_b = 8'd0;
        @(negedge clk);
        vectors++; if (f_done !== 1'b1) begin miscompares++; $display("FAIL full_select_done: got %b want 1", f_done); end
        f_op = 2'd1; f_a = 8'hFE; f_b = 8'h07;
        @(negedge clk);
        f_valid = 1'b0;
        bad = 0; dn = 0;
        for (int k = 0; k < 200; k++) begin
            if (f_we !== 1'b1 || int'(f_waddr) != 128000 + k || f_wdata !== 4'd7 || f_ready !== 1'b0) bad++;
            if (f_done) dn++;
            @(negedge clk);
        end
        vectors++; if (bad != 0 || dn != 0) begin miscompares++; $display("FAIL full_fill: got %0d bad, %0d done want 0/0", bad, dn); end
        f_reset = 1'b0; #1;
        vectors++; if (f_we !== 1'b0) begin miscompares++; $display("FAIL full_fill_abort: got we=%b want 0", f_we); end
        @(negedge clk); f_reset = 1'b1; @(negedge clk);
        f_valid = 1'b1; f_op = 2'd2; f_a = 8'd1; f_b = 8'd3;
        @(negedge clk);
        f_valid = 1'b0;
        bad = 0;
        for (int k = 0; k <= 200; k++) begin
            if (k < 200 && (f_re !== 1'b1 || int'(f_raddr) != 64000 + k)) bad++;
            if (k == 0 && f_we !== 1'b0) bad++;
            if (k >= 1 && (f_we !== 1'b1 || int'(f_waddr) != 192000 + k - 1 || int'(f_wdata) != ((64000 + k - 1) & 15))) bad++;
            @(negedge clk);
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL full_copy: got %0d bad want 0", bad); end
        f_reset = 1'b0; @(negedge clk); f_reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg_a = '0; cmd_arg_b = '0;
        f_reset = 1'b0; f_valid = 1'b0; f_op = '0; f_a = '0; f_b = '0;
        test_reset();
        test_fill();
        test_copy();
        test_blit();
        test_reset_abort();
        test_full_size();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
